// File: rtl/key_expansion_seq.sv
// -----------------------------------------------------------------------------
// key_expansion_seq
//
// Iterative AES key schedule (AES-128/192/256 selected by Nk/Nr). After a
// start request the cipher key is loaded into words 0..Nk-1 and one further
// 32-bit schedule word is produced per clock, so a single SubWord (four
// S-boxes) serves the whole schedule. The finished schedule is held in
// registers and presented on o_all_keys for the encrypt/decrypt round engines.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_reset      synchronous active-high reset (priority over i_start)
//   i_start      begins an expansion when idle or done; ignored while busy
//   i_key        cipher key, word 0 in the most significant 32 bits
//   o_all_keys   registered schedule; word i at [(W-i)*32-1 -: 32], so round 0
//                is the top 128 bits and round Nr is bits [127:0]
//   o_busy       high while schedule words are being generated
//   o_keys_valid level, schedule complete and stable
//   o_done       one-cycle pulse in the first cycle the schedule is complete
// -----------------------------------------------------------------------------
module key_expansion_seq #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [Nk*32-1:0]       i_key,
    output logic [(Nr+1)*128-1:0]  o_all_keys,
    output logic                   o_busy,
    output logic                   o_keys_valid,
    output logic                   o_done
);

    localparam int unsigned W    = 4 * (Nr + 1);
    localparam int unsigned IdxW = $clog2(W);

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTable[2047 - 8 * int'(b) -: 8];
    endfunction

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StExpand = 2'd1,
        StDone   = 2'd2
    } state_e;

    state_e r_state;
    state_e w_next_state;

    logic   w_load;   // capture key and restart the schedule
    logic   w_step;   // generate the word at r_idx
    logic   w_last;   // the word being generated is the final one

    // Full schedule storage; drives o_all_keys directly.
    logic [31:0]     r_w [W];
    // Sliding window of the last Nk words: r_win[0] = w[i-Nk], r_win[Nk-1] = w[i-1].
    // Keeps the recurrence operands local instead of muxing them out of r_w.
    logic [31:0]     r_win [Nk];
    logic [IdxW-1:0] r_idx;
    logic [2:0]      r_phase;  // i mod Nk, tracked as a wrapping counter
    logic [7:0]      r_rcon;
    logic            r_busy;
    logic            r_keys_valid;
    logic            r_done;

    logic [31:0] w_prev;
    logic [31:0] w_rot;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub_out;
    logic [31:0] w_temp;
    logic [31:0] w_new;
    logic        w_phase0;
    logic        w_phase4;
    logic [7:0]  w_rcon_next;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_next_state = StExpand;
                end
            end
            StExpand: begin
                w_step = 1'b1;
                if (r_idx == IdxW'(W - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = StDone;
                end
            end
            default: w_next_state = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Word generation: one shared SubWord, fed by RotWord(w[i-1]) on
    // phase 0 and by w[i-1] itself on the AES-256 phase-4 word.
    // ------------------------------------------------------------------
    assign w_prev   = r_win[Nk-1];
    assign w_rot    = {w_prev[23:0], w_prev[31:24]};
    assign w_phase0 = (r_phase == 3'd0);
    assign w_phase4 = (Nk > 6) && (r_phase == 3'd4);
    assign w_sub_in = w_phase0 ? w_rot : w_prev;

    assign w_sub_out = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                        sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};

    always_comb begin
        w_temp = w_prev;
        if (w_phase0) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        end else if (w_phase4) begin
            w_temp = w_sub_out;
        end
    end

    assign w_new       = r_win[0] ^ w_temp;
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // ------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < W; k++) begin
                r_w[k] <= '0;
            end
            for (int k = 0; k < Nk; k++) begin
                r_win[k] <= '0;
            end
            r_idx        <= '0;
            r_phase      <= 3'd0;
            r_rcon       <= 8'h01;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                // Clear everything, then overlay the key words.
                for (int k = 0; k < W; k++) begin
                    r_w[k] <= '0;
                end
                for (int k = 0; k < Nk; k++) begin
                    r_w[k]   <= i_key[(Nk-k)*32-1 -: 32];
                    r_win[k] <= i_key[(Nk-k)*32-1 -: 32];
                end
                r_idx        <= IdxW'(Nk);
                r_phase      <= 3'd0;
                r_rcon       <= 8'h01;
                r_busy       <= 1'b1;
                r_keys_valid <= 1'b0;
            end else if (w_step) begin
                for (int k = Nk; k < W; k++) begin
                    if (r_idx == IdxW'(k)) begin
                        r_w[k] <= w_new;
                    end
                end
                for (int k = 0; k < Nk - 1; k++) begin
                    r_win[k] <= r_win[k+1];
                end
                r_win[Nk-1] <= w_new;
                r_idx       <= r_idx + 1'b1;
                r_phase     <= (r_phase == 3'(Nk - 1)) ? 3'd0 : r_phase + 3'd1;
                if (w_phase0) begin
                    r_rcon <= w_rcon_next;
                end
                if (w_last) begin
                    r_busy       <= 1'b0;
                    r_keys_valid <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < W; g++) begin : g_pack
        assign o_all_keys[(W-g)*32-1 -: 32] = r_w[g];
    end

    assign o_busy       = r_busy;
    assign o_keys_valid = r_keys_valid;
    assign o_done       = r_done;

endmodule

// File: tb/tb_key_expansion_seq.sv
// -----------------------------------------------------------------------------
// tb_key_expansion_seq
//
// Drives AES-128, AES-192 and AES-256 instances of key_expansion_seq with
// directed vectors. A behavioural key-schedule model (S-box derived from the
// GF(2^8) inverse plus affine map) predicts status outputs and the finished
// schedule; known-answer vectors pin both the model and the design.
// -----------------------------------------------------------------------------
module tb_key_expansion_seq;

    logic clk;
    logic rst;
    logic [2:0]   start_v;
    logic [255:0] key_v [3];

    logic [1407:0] ak0;
    logic [1663:0] ak1;
    logic [1919:0] ak2;
    logic busy0, busy1, busy2;
    logic kv0, kv1, kv2;
    logic done0, done1, done2;

    wire [2:0] busy_v = {busy2, busy1, busy0};
    wire [2:0] kv_v   = {kv2, kv1, kv0};
    wire [2:0] done_v = {done2, done1, done0};

    int n_cmp;
    int n_err;
    bit chk_en;

    key_expansion_seq #(.Nk(4), .Nr(10)) u_aes128 (
        .i_clk(clk), .i_reset(rst), .i_start(start_v[0]), .i_key(key_v[0][127:0]),
        .o_all_keys(ak0), .o_busy(busy0), .o_keys_valid(kv0), .o_done(done0)
    );
    key_expansion_seq #(.Nk(6), .Nr(12)) u_aes192 (
        .i_clk(clk), .i_reset(rst), .i_start(start_v[1]), .i_key(key_v[1][191:0]),
        .o_all_keys(ak1), .o_busy(busy1), .o_keys_valid(kv1), .o_done(done1)
    );
    key_expansion_seq #(.Nk(8), .Nr(14)) u_aes256 (
        .i_clk(clk), .i_reset(rst), .i_start(start_v[2]), .i_key(key_v[2][255:0]),
        .o_all_keys(ak2), .o_busy(busy2), .o_keys_valid(kv2), .o_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h00;
        if (b != 8'h00) begin
            for (int c = 1; c < 256; c++) begin
                if (gf_mul(b, 8'(c)) == 8'h01) inv = 8'(c);
            end
        end
        return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_m(x[31:24]), sbox_m(x[23:16]), sbox_m(x[15:8]), sbox_m(x[7:0])};
    endfunction

    // Full schedule, right-aligned in 1920 bits, packed as the DUT packs it.
    function automatic logic [1919:0] expand(input int nk, input logic [255:0] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int nw;
        nw = 4 * (nk + 7);
        r  = '0;
        for (int j = 0; j < nk; j++) w[j] = k[(nk-j)*32-1 -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int e = 1; e < i / nk; e++) rc = gf_mul(rc, 8'h02);
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) r[(nw-i)*32-1 -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [1919:0] ak_of(input int n);
        case (n)
            0:       return {512'b0, ak0};
            1:       return {256'b0, ak1};
            default: return ak2;
        endcase
    endfunction

    bit            m_busy  [3];
    bit            m_valid [3];
    bit            m_done  [3];
    bit            m_known [3];
    int            m_cnt   [3];
    logic [1919:0] m_exp   [3];
    logic [1919:0] m_tgt   [3];

    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (rst) begin
                m_busy[n]  <= 1'b0;
                m_valid[n] <= 1'b0;
                m_done[n]  <= 1'b0;
                m_known[n] <= 1'b1;
                m_cnt[n]   <= 0;
                m_exp[n]   <= '0;
            end else begin
                m_done[n] <= 1'b0;
                if (m_busy[n]) begin
                    m_cnt[n] <= m_cnt[n] - 1;
                    if (m_cnt[n] == 1) begin
                        m_busy[n]  <= 1'b0;
                        m_valid[n] <= 1'b1;
                        m_done[n]  <= 1'b1;
                        m_known[n] <= 1'b1;
                        m_exp[n]   <= m_tgt[n];
                    end
                end else if (start_v[n]) begin
                    m_busy[n]  <= 1'b1;
                    m_valid[n] <= 1'b0;
                    m_known[n] <= 1'b0;
                    m_cnt[n]   <= 4 * (4 + 2 * n + 7) - (4 + 2 * n);
                    m_tgt[n]   <= expand(4 + 2 * n, key_v[n]);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_wide(input int n, input logic [1919:0] act, input logic [1919:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            for (int j = 0; j < 60; j++) begin
                if (act[j*32 +: 32] !== exp[j*32 +: 32]) begin
                    if (n_err <= 40)
                        $display("FAIL all_keys inst%0d bits[%0d+:32]: got %h want %h",
                                 n, j * 32, act[j*32 +: 32], exp[j*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic chk_bit(input string nm, input int n, input logic act, input logic exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            if (n_err <= 40) $display("FAIL %s inst%0d @%0t: got %b want %b", nm, n, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int n = 0; n < 3; n++) begin
                chk_bit("busy", n, busy_v[n], m_busy[n]);
                chk_bit("keys_valid", n, kv_v[n], m_valid[n]);
                chk_bit("done", n, done_v[n], m_done[n]);
                if (m_known[n]) chk_wide(n, ak_of(n), m_exp[n]);
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K2B  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    // Start instance n, optionally re-pulse start with alt key at cycle inj,
    // then wait (bounded) for done and check latency and busy duration.
    task automatic run_wait(input int n, input logic [255:0] k, input int lat,
                            input int inj, input logic [255:0] alt);
        int cyc;
        int bcnt;
        key_v[n]   = k;
        start_v[n] = 1'b1;
        @(negedge clk);
        start_v[n] = 1'b0;
        chk($sformatf("keys_valid_low_after_start%0d", n), 128'(kv_v[n]), 128'd0);
        cyc  = 0;
        bcnt = 0;
        while (!done_v[n] && cyc < 200) begin
            if (busy_v[n]) bcnt++;
            @(negedge clk);
            cyc++;
            start_v[n] = 1'b0;
            if (cyc == inj) begin
                key_v[n]   = alt;
                start_v[n] = 1'b1;
            end
        end
        start_v[n] = 1'b0;
        chk($sformatf("latency%0d", n), 128'(cyc), 128'(lat));
        chk($sformatf("busy_cycles%0d", n), 128'(bcnt), 128'(lat));
    endtask

    logic [1919:0] tmp;

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        chk_en  = 1'b0;
        rst     = 1'b1;
        start_v = 3'b000;
        for (int n = 0; n < 3; n++) key_v[n] = '0;

        // Pin the model with known-answer words.
        tmp = expand(4, K2B);
        chk("model_w4", 128'(tmp[1279 -: 32]), 128'h00000000_00000000_00000000_a0fafe17);
        chk("model_w43", 128'(tmp[31:0]), 128'h00000000_00000000_00000000_b6630ca6);
        tmp = expand(8, K256);
        chk("model_256_last", tmp[127:0], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;
        chk("reset_all_keys_hi", ak0[1407:1280], 128'd0);
        chk("reset_status", 128'({busy0, kv0, done0}), 128'd0);

        // AES-128 FIPS-197 C.1 key.
        run_wait(0, K128, 40, -1, '0);
        chk("aes128_round0", ak0[1407:1280], K128[127:0]);
        chk("aes128_round10", ak0[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Restart from DONE; a mid-run start with a different key is ignored.
        run_wait(0, K2B, 40, 10, 256'hffeeddccbbaa99887766554433221100);
        chk("aes128_w4", 128'(ak0[1279 -: 32]), 128'h00000000_00000000_00000000_a0fafe17);
        chk("aes128_w43", 128'(ak0[31:0]), 128'h00000000_00000000_00000000_b6630ca6);
        chk("aes128_round0_2b", ak0[1407:1280], K2B[127:0]);

        run_wait(1, K192, 46, -1, '0);
        chk("aes192_round12", ak1[127:0], 128'ha4970a331a78dc09c418c271e3a41d5d);

        run_wait(2, K256, 52, -1, '0);
        chk("aes256_round14", ak2[127:0], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Reset in the middle of an AES-128 expansion.
        key_v[0]   = K128;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_all_keys_hi", ak0[1407:1280], 128'd0);
        chk("abort_all_keys_lo", ak0[127:0], 128'd0);
        chk("abort_status", 128'({busy0, kv0, done0}), 128'd0);
        repeat (25) @(negedge clk);
        chk("abort_no_done", 128'({done0, kv0}), 128'd0);

        run_wait(0, K128, 40, -1, '0);
        chk("restart_round10", ak0[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
